// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that assembles BYTES bytes (byte 0 = LSB lane) into one word.
// Optional RX_TIMEOUT_EN drops a partial word after TIMEOUT_BITS idle bit-periods.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 2494,
    parameter int BYTES        = 4,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [8*BYTES-1:0]   data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           byte_cnt
);

    localparam logic [12:0] MID  = 13'((CLKS_PER_BIT - 1) / 2);
    localparam logic [12:0] FULL = 13'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    logic                 sync_p0;
    logic                 sync_p1;
    logic                 line;
    logic [12:0]          timer;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic [3:0]           cnt;
    logic [8*BYTES-1:0]   staging;

`ifdef RX_TIMEOUT_EN
    localparam int             TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int             TO_W     = $clog2(TO_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
    logic [TO_W-1:0]           to_cnt;
`endif

    assign line     = sync_p1;
    assign byte_cnt = cnt[2:0];
    assign busy     = (state != IDLE) || (cnt != 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            cnt        <= '0;
            staging    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            // Stage p0/p1: two-flop synchronizer on the asynchronous line
            sync_p0    <= rx_in;
            sync_p1    <= sync_p0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
            to_cnt     <= '0;
`endif
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (!line) begin
                        state <= START;
`ifdef RX_TIMEOUT_EN
                    end else if (cnt != 4'd0) begin
                        // A start edge takes priority; the timeout only runs on an idle line
                        if (to_cnt == TO_LAST) begin
                            cnt     <= '0;
                            staging <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end

                START: begin
                    if (timer == MID) begin
                        timer <= '0;
                        state <= line ? IDLE : DATA;
                    end else begin
                        timer <= timer + 13'd1;
                    end
                end

                DATA: begin
                    if (timer == FULL) begin
                        timer   <= '0;
                        shreg   <= {line, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + 13'd1;
                    end
                end

                STOP: begin
                    if (timer == FULL) begin
                        timer <= '0;
                        if (line) begin
                            for (int k = 0; k < BYTES; k++) begin
                                if (cnt == 4'(k)) begin
                                    staging[8*k +: 8] <= shreg;
                                end
                            end
                            cnt   <= cnt + 4'd1;
                            state <= ((cnt + 4'd1) == 4'(BYTES)) ? DONE : IDLE;
                        end else begin
                            // Bad stop bit poisons the whole word, not just this byte
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            staging   <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        timer <= timer + 13'd1;
                    end
                end

                DONE: begin
                    data_out   <= staging;
                    data_valid <= 1'b1;
                    cnt        <= '0;
                    timer      <= '0;
                    state      <= IDLE;
                end

                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: expected words are queued as frames are driven
// and popped by a monitor on each data_valid pulse.
module tb_uart_rx_word;

    localparam int CPB   = 16;
    localparam int BYTES = 4;
    localparam int TOB   = 4;
    localparam int W     = 8 * BYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_line;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         busy;
    logic [2:0]   byte_cnt;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int dv_cnt  = 0;
    int fe_cnt  = 0;
    int last_dv = 0;
    int prev_dv = 0;
    logic [W-1:0] exp_q[$];

    uart_rx_word #(
        .CLKS_PER_BIT(CPB),
        .BYTES(BYTES),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_line),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .busy(busy),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every data_valid cycle
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) fe_cnt++;
            if (data_valid) begin
                logic [W-1:0] exp_w;
                dv_cnt++;
                prev_dv = last_dv;
                last_dv = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: data_out=%h, no word expected", data_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (data_out !== exp_w) begin
                        errors++;
                        $display("FAIL word_value: data_out=%h expected %h", data_out, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int k = 0; k < BYTES; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic drain;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rx_line = 1'b1;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_out, data_valid, frame_err, busy, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_in: data_out=%h dv=%b fe=%b busy=%b cnt=%0d, expected all 0",
                     data_out, data_valid, frame_err, busy, byte_cnt);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({data_out, data_valid, frame_err, busy, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_out: data_out=%h dv=%b fe=%b busy=%b cnt=%0d, expected all 0",
                     data_out, data_valid, frame_err, busy, byte_cnt);
        end
    endtask

    task automatic test_basic_word;
        int dv0 = dv_cnt;
        int fe0 = fe_cnt;
        logic [W-1:0] w = 32'h11223344;
        exp_q.push_back(w);
        for (int k = 0; k < BYTES; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
            checks++;
            if (k < BYTES - 1) begin
                if (byte_cnt !== 3'(k + 1) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_progress: byte_cnt=%0d busy=%b, expected %0d and 1",
                             byte_cnt, busy, k + 1);
                end
            end else if (byte_cnt !== 3'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_end: byte_cnt=%0d busy=%b, expected 0 and 0", byte_cnt, busy);
            end
        end
        drain();
        checks++;
        if (dv_cnt - dv0 != 1 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL basic_pulses: valid=%0d frame_err=%0d, expected 1 and 0",
                     dv_cnt - dv0, fe_cnt - fe0);
        end
        checks++;
        if (data_out !== 32'h11223344) begin
            errors++;
            $display("FAIL basic_hold: data_out=%h expected 11223344", data_out);
        end
    endtask

    task automatic test_reset_midframe;
        int dv0;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (byte_cnt !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_state: byte_cnt=%0d busy=%b, expected 2 and 1", byte_cnt, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, busy, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: data_out=%h dv=%b fe=%b busy=%b cnt=%0d, expected all 0",
                     data_out, data_valid, frame_err, busy, byte_cnt);
        end
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        dv0 = dv_cnt;
        exp_q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        drain();
        checks++;
        if (dv_cnt - dv0 != 1 || data_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL after_reset_word: valid=%0d data_out=%h, expected 1 and deadbeef",
                     dv_cnt - dv0, data_out);
        end
    endtask

    task automatic test_frame_error;
        int dv0 = dv_cnt;
        int fe0 = fe_cnt;
        send_byte(8'hA5, 1'b1);
        checks++;
        if (byte_cnt !== 3'd1) begin
            errors++;
            $display("FAIL ferr_first: byte_cnt=%0d expected 1", byte_cnt);
        end
        send_byte(8'h5A, 1'b0);
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1 || byte_cnt !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse: frame_err=%0d byte_cnt=%0d busy=%b, expected 1, 0, 0",
                     fe_cnt - fe0, byte_cnt, busy);
        end
        checks++;
        if (data_out !== 32'hDEADBEEF || dv_cnt != dv0) begin
            errors++;
            $display("FAIL ferr_hold: data_out=%h valid=%0d, expected deadbeef and 0",
                     data_out, dv_cnt - dv0);
        end
        exp_q.push_back(32'h04030201);
        send_word(32'h04030201);
        drain();
        checks++;
        if (dv_cnt - dv0 != 1 || fe_cnt - fe0 != 1 || data_out !== 32'h04030201) begin
            errors++;
            $display("FAIL ferr_recover: valid=%0d frame_err=%0d data_out=%h, expected 1, 1, 04030201",
                     dv_cnt - dv0, fe_cnt - fe0, data_out);
        end
    endtask

    task automatic test_glitch;
        int   dv0 = dv_cnt;
        int   fe0 = fe_cnt;
        logic saw_busy = 1'b0;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        checks++;
        if (busy !== 1'b0 || saw_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: busy=%b seen_busy=%b, expected 0 and 1", busy, saw_busy);
        end
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (dv_cnt != dv0 || fe_cnt != fe0 || byte_cnt !== 3'd0) begin
            errors++;
            $display("FAIL glitch_quiet: valid=%0d frame_err=%0d byte_cnt=%0d, expected 0, 0, 0",
                     dv_cnt - dv0, fe_cnt - fe0, byte_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int dv0 = dv_cnt;
        exp_q.push_back(32'h89ABCDEF);
        exp_q.push_back(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'h01234567);
        drain();
        checks++;
        if (dv_cnt - dv0 != 2) begin
            errors++;
            $display("FAIL b2b_count: valid=%0d expected 2", dv_cnt - dv0);
        end
        checks++;
        if (last_dv - prev_dv != BYTES * 10 * CPB) begin
            errors++;
            $display("FAIL b2b_spacing: gap=%0d cycles expected %0d", last_dv - prev_dv, BYTES * 10 * CPB);
        end
    endtask

    task automatic test_timeout;
        logic [W-1:0] exp_w;
        logic [2:0]   exp_cnt;
`ifdef RX_TIMEOUT_EN
        exp_w   = 32'hCAFEF00D;
        exp_cnt = 3'd0;
`else
        exp_w   = 32'hF00D6677;
        exp_cnt = 3'd2;
`endif
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        repeat (70) @(negedge clk);
        checks++;
        if (byte_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_idle: byte_cnt=%0d expected %0d", byte_cnt, exp_cnt);
        end
        exp_q.push_back(exp_w);
        send_word(32'hCAFEF00D);
        drain();
        checks++;
        if (data_out !== exp_w || byte_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_word: data_out=%h byte_cnt=%0d, expected %h and %0d",
                     data_out, byte_cnt, exp_w, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_reset_midframe();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_timeout();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
